hazard_sequencer: RTL

Central pipeline-hazard controller for the 5-stage MIPS core.
- Merges the combinational load-use stall request with multi-cycle multiply/divide unit (MDU) occupancy and taken branch/jump redirects.
- Drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble.
- Sequences MDU occupancy with an internal FSM and counter, and keeps a saturating stall-cycle statistic.

---
 rtl/hazard_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: central pipeline-hazard controller for the 5-stage MIPS core.
// Merges load-use stalls, MDU occupancy and taken redirects into the PC/IF/ID
// enables, the IF/ID flush and the ID/EX bubble, sequences the multi-cycle
// MULT/DIV unit, and keeps a saturating count of stalled cycles.
module hazard_sequencer #(
    parameter int MULT_CYCLES = 4,   // legal range 2..15
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active-low
    input  logic             LoadUseHazard,
    input  logic             MultIssue,
    input  logic             HiLoRead,
    input  logic             BranchTaken,
    input  logic             JumpTaken,
    input  logic             StatClear,
    output logic             PC_WriteEnable,
    output logic             IFID_WriteEnable,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MultBusy,
    output logic             HiLoWrite,
    output logic [3:0]       MultCount,
    output logic [CNT_W-1:0] StallCycles,
    output logic [1:0]       MduState
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    localparam logic [3:0] LOAD_COUNT = 4'(MULT_CYCLES);

    mdu_state_e state, state_nxt;
    logic [3:0] count, count_nxt;
    logic       mdu_busy;
    logic       stall;
    logic       accept;

    // An MDU op in flight blocks a second issue and any HI/LO read; a
    // load-use hazard always stalls. Issue is accepted only when not stalled.
    assign mdu_busy = (state == BUSY);
    assign stall    = LoadUseHazard | (mdu_busy & (MultIssue | HiLoRead));
    assign accept   = MultIssue & ~stall;

    // State register: an asynchronous reset abandons any MDU op in flight.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state logic for MDU occupancy and the remaining-cycle counter.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals; otherwise
        // synthesis infers latches to hold the missing values.
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = BUSY;
                    count_nxt = LOAD_COUNT;
                end
            end
            BUSY: begin
                if (count == 4'd1) begin
                    state_nxt = DONE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count - 4'd1;
                end
            end
            DONE: begin
                // HI/LO commits this cycle; a new op may start back-to-back.
                if (accept) begin
                    state_nxt = BUSY;
                    count_nxt = LOAD_COUNT;
                end else begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // Output logic: reset forces a frozen, squashed front end; otherwise
    // stall beats redirect, and a redirect flushes the fetched slot.
    always_comb begin
        PC_WriteEnable   = 1'b1;
        IFID_WriteEnable = 1'b1;
        IFID_Flush       = 1'b0;
        IDEX_Bubble      = 1'b0;
        if (!reset) begin
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
            IFID_Flush       = 1'b1;
            IDEX_Bubble      = 1'b1;
        end else if (stall) begin
            PC_WriteEnable   = 1'b0;
            IFID_WriteEnable = 1'b0;
            IDEX_Bubble      = 1'b1;
        end else if (BranchTaken | JumpTaken) begin
            IFID_Flush       = 1'b1;
        end
        MultBusy  = mdu_busy;
        HiLoWrite = (state == DONE);
        MultCount = count;
        MduState  = state;
    end

    // Saturating stalled-cycle statistic; a clear wins over a same-cycle stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCycles <= '0;
        end else if (StatClear) begin
            StallCycles <= '0;
        end else if (!PC_WriteEnable && !(&StallCycles)) begin
            StallCycles <= StallCycles + 1'b1;
        end
    end

endmodule
